// File: rtl/btn_pkg.sv
// Shared widths, button indices and repeat-state encoding for the
// front-panel button conditioner.
package btn_pkg;

    localparam int BTN_W      = 5;
    localparam int BTN_UP     = 0;
    localparam int BTN_DOWN   = 1;
    localparam int BTN_LEFT   = 2;
    localparam int BTN_RIGHT  = 3;
    localparam int BTN_CENTER = 4;

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        RATE
    } rpt_state_e;

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: two-flop synchroniser, counter debouncer, rising-edge
// press pulse and optional hold-to-repeat state machine.
module btn_debounce_ch
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 330000,
    parameter int REPEAT_DELAY    = 16500000,
    parameter int REPEAT_RATE     = 4950000,
    parameter bit REPEAT_EN       = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_i,
    output logic level_o,
    output logic press_o
);

    localparam int DB_W    = $clog2(DEBOUNCE_CYCLES);
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RPT_W   = $clog2(RPT_MAX);

    localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RPT_W-1:0] DELAY_LAST = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RATE_LAST  = RPT_W'(REPEAT_RATE - 1);

    logic             sync1_q, sync2_q;
    logic             stable_q, stable_d;
    logic             prev_q;
    logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
    logic [RPT_W-1:0] rpt_cnt_q;
    rpt_state_e       state_q;
    logic             press_q;
    logic             rise;

    // Any agreeing sample throws away the accumulated disagreement count.
    always_comb begin
        stable_d = stable_q;
        db_cnt_d = '0;
        if (sync2_q != stable_q) begin
            if (db_cnt_q == DB_LAST) begin
                stable_d = ~stable_q;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
    end

    assign rise = stable_q & ~prev_q;

    // Repeat decisions use the next stable value so no pulse escapes on the release edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            stable_q  <= 1'b0;
            prev_q    <= 1'b0;
            db_cnt_q  <= '0;
            rpt_cnt_q <= '0;
            state_q   <= IDLE;
            press_q   <= 1'b0;
        end else begin
            sync1_q  <= raw_i;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            db_cnt_q <= db_cnt_d;
            prev_q   <= stable_q;
            press_q  <= rise;
            case (state_q)
                IDLE: begin
                    rpt_cnt_q <= '0;
                    if (rise && REPEAT_EN) begin
                        state_q <= DELAY;
                    end
                end
                DELAY: begin
                    if (!stable_d) begin
                        state_q   <= IDLE;
                        rpt_cnt_q <= '0;
                    end else if (rpt_cnt_q == DELAY_LAST) begin
                        press_q   <= 1'b1;
                        state_q   <= RATE;
                        rpt_cnt_q <= '0;
                    end else begin
                        rpt_cnt_q <= rpt_cnt_q + 1'b1;
                    end
                end
                RATE: begin
                    if (!stable_d) begin
                        state_q   <= IDLE;
                        rpt_cnt_q <= '0;
                    end else if (rpt_cnt_q == RATE_LAST) begin
                        press_q   <= 1'b1;
                        rpt_cnt_q <= '0;
                    end else begin
                        rpt_cnt_q <= rpt_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    rpt_cnt_q <= '0;
                end
            endcase
        end
    end

    assign level_o = stable_q;
    assign press_o = press_q;

endmodule

// File: rtl/btn_conditioner.sv
// Conditions the five front-panel buttons: one independent channel per button,
// plus a combined press strobe.
module btn_conditioner
    import btn_pkg::*;
#(
    parameter int               DEBOUNCE_CYCLES = 330000,
    parameter int               REPEAT_DELAY    = 16500000,
    parameter int               REPEAT_RATE     = 4950000,
    parameter logic [BTN_W-1:0] REPEAT_MASK     = 5'b01111
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [BTN_W-1:0] btn_raw,
    output logic [BTN_W-1:0] btn_level,
    output logic [BTN_W-1:0] btn_press,
    output logic             any_press
);

    for (genvar i = 0; i < BTN_W; i++) begin : g_ch
        btn_debounce_ch #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_RATE    (REPEAT_RATE),
            .REPEAT_EN      (REPEAT_MASK[i])
        ) u_ch (
            .clk    (clk),
            .rst    (rst),
            .raw_i  (btn_raw[i]),
            .level_o(btn_level[i]),
            .press_o(btn_press[i])
        );
    end

    assign any_press = |btn_press;

endmodule

// File: tb/tb_btn_conditioner.sv
// Randomised and directed stimulus for btn_conditioner, checked every cycle
// against a timing-rule reference model through an expectation queue.
module tb_btn_conditioner;

    localparam int          DC   = 4;
    localparam int          RD   = 20;
    localparam int          RR   = 5;
    localparam logic [4:0]  MASK = 5'b01111;

    typedef struct packed {
        logic [4:0] press;
        logic [4:0] level;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] btn_raw = '0;
    logic [4:0] btn_level;
    logic [4:0] btn_press;
    logic       any_press;

    exp_t expQ[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state: pipeline samples, debounced level and press times.
    bit s1[5], s2[5], stab[5], pend[5], held[5];
    int lastAgree[5], pTime[5];
    int t = 0;

    btn_conditioner #(
        .DEBOUNCE_CYCLES(DC),
        .REPEAT_DELAY   (RD),
        .REPEAT_RATE    (RR),
        .REPEAT_MASK    (MASK)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_raw  (btn_raw),
        .btn_level(btn_level),
        .btn_press(btn_press),
        .any_press(any_press)
    );

    always #5 clk = ~clk;

    // Level flips once DC consecutive edges have seen a disagreeing sample;
    // repeats are scheduled arithmetically from the initial press time.
    task automatic stepModel(input logic [4:0] raw, input logic r, output exp_t e);
        t++;
        for (int i = 0; i < 5; i++) begin
            bit oldStab;
            bit p;
            p = 1'b0;
            if (r) begin
                s1[i] = 0; s2[i] = 0; stab[i] = 0; pend[i] = 0; held[i] = 0;
                lastAgree[i] = t;
                pTime[i] = t;
            end else begin
                oldStab = stab[i];
                if (s2[i] == stab[i]) begin
                    lastAgree[i] = t;
                end else if (t - lastAgree[i] == DC) begin
                    stab[i] = ~stab[i];
                    lastAgree[i] = t;
                end
                s2[i] = s1[i];
                s1[i] = raw[i];
                if (pend[i]) begin
                    p = 1'b1;
                    pTime[i] = t;
                    held[i] = MASK[i];
                    pend[i] = 0;
                end
                if (stab[i] && !oldStab) pend[i] = 1;
                if (!stab[i]) begin
                    held[i] = 0;
                end else if (held[i] && (t - pTime[i] >= RD) && ((t - pTime[i] - RD) % RR == 0)) begin
                    p = 1'b1;
                end
            end
            e.press[i] = p;
            e.level[i] = stab[i];
        end
    endtask

    task automatic applyStimulus(input logic [4:0] raw, input logic r);
        exp_t e;
        @(negedge clk);
        btn_raw = raw;
        rst = r;
        stepModel(raw, r, e);
        expQ.push_back(e);
    endtask

    task automatic holdFor(input logic [4:0] raw, input int n);
        for (int k = 0; k < n; k++) applyStimulus(raw, 1'b0);
    endtask

    task automatic checkOutput(input exp_t e);
        checks += 3;
        if (btn_press !== e.press) begin
            errors++;
            $display("[TB] FAIL press t=%0d got=%b exp=%b", t, btn_press, e.press);
        end
        if (btn_level !== e.level) begin
            errors++;
            $display("[TB] FAIL level t=%0d got=%b exp=%b", t, btn_level, e.level);
        end
        if (any_press !== (|e.press)) begin
            errors++;
            $display("[TB] FAIL any_press t=%0d got=%b exp=%b", t, any_press, |e.press);
        end
    endtask

    // Monitor: every cycle the DUT presents a result, compared with the oldest expectation.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() > 0) checkOutput(expQ.pop_front());
        end
    end

    // Directed scenarios first, then a long randomised run with bounces and resets.
    initial begin
        logic [4:0] cur;
        logic [4:0] drv;
        logic       r;
        for (int k = 0; k < 3; k++) applyStimulus(5'b00000, 1'b1);
        holdFor(5'b00000, 3);

        holdFor(5'b10000, 100);
        holdFor(5'b00000, 15);

        applyStimulus(5'b00001, 1'b0);
        applyStimulus(5'b00001, 1'b0);
        applyStimulus(5'b00001, 1'b0);
        applyStimulus(5'b00000, 1'b0);
        applyStimulus(5'b00001, 1'b0);
        applyStimulus(5'b00001, 1'b0);
        applyStimulus(5'b00001, 1'b0);
        applyStimulus(5'b00000, 1'b0);
        holdFor(5'b00001, 12);
        holdFor(5'b00000, 15);

        holdFor(5'b00100, 66);
        holdFor(5'b00000, 15);

        holdFor(5'b01010, 12);
        holdFor(5'b00000, 15);

        holdFor(5'b00001, 15);
        applyStimulus(5'b00001, 1'b1);
        holdFor(5'b00001, 20);
        holdFor(5'b00000, 15);

        holdFor(5'b00100, 31);
        holdFor(5'b00000, 15);
        holdFor(5'b00100, 40);
        holdFor(5'b00000, 15);

        cur = '0;
        for (int k = 0; k < 2500; k++) begin
            for (int i = 0; i < 5; i++) begin
                if ($urandom_range(0, 39) == 0) cur[i] = ~cur[i];
            end
            drv = cur;
            if ($urandom_range(0, 7) == 0) drv[$urandom_range(0, 4)] ^= 1'b1;
            r = ($urandom_range(0, 499) == 0);
            applyStimulus(drv, r);
        end
        holdFor(5'b00000, 2);

        repeat (3) @(posedge clk);
        #2;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
